// File: rtl/gth_rst_seq.sv
`default_nettype none
// =============================================================================
// Module   : gth_rst_seq
// Brief    : GTH transceiver reset sequencer: timed reset pulse, lock wait with
//            settle filter, timeout retry, auto relock and a 32-bit status word.
// Revision : 1.0 - initial release
// =============================================================================
module gth_rst_seq #(
    parameter int unsigned RST_CYCLES    = 64,
    parameter int unsigned LOCK_TIMEOUT  = 1000000,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned MAX_RETRY     = 3,
    parameter logic [3:0]  LOCK_MASK     = 4'b1111,
    parameter bit          AUTO_RELOCK   = 1'b1
) (
    input  logic        i_up_clk,
    input  logic        i_up_rst,
    input  logic        i_rst_req,
    input  logic [3:0]  i_gth_status,
    output logic        o_gth_rst,
    output logic        o_locked,
    output logic        o_busy,
    output logic [31:0] o_stat_word
);

    localparam int c_PC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int c_TC_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int c_SC_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [c_PC_W-1:0] c_PC_LAST   = c_PC_W'(RST_CYCLES - 1);
    localparam logic [c_TC_W-1:0] c_TC_LAST   = c_TC_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_SC_W-1:0] c_SC_LAST   = c_SC_W'(SETTLE_CYCLES);
    localparam logic [3:0]        c_MAX_RETRY = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ASSERT    = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_LOCKED    = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_PC_W-1:0]   r_pc;
    logic [c_TC_W-1:0]   r_tc;
    logic [c_SC_W-1:0]   r_sc;
    logic [3:0]          r_retry;
    logic [7:0]          r_loss;
    logic                r_timeout;
    logic                r_req_d;
    logic [3:0]          r_sync1;
    logic [3:0]          r_sync2;

    state_t              w_state_nxt;
    logic [c_PC_W-1:0]   w_pc_nxt;
    logic [c_TC_W-1:0]   w_tc_nxt;
    logic [c_SC_W-1:0]   w_sc_nxt;
    logic [3:0]          w_retry_nxt;
    logic [7:0]          w_loss_nxt;
    logic                w_timeout_nxt;
    logic                w_req_edge;
    logic                w_ok;
    logic                w_tc_last;

    assign w_req_edge = i_rst_req & ~r_req_d;
    assign w_ok       = ((r_sync2 & LOCK_MASK) == LOCK_MASK);
    assign w_tc_last  = (r_tc == c_TC_LAST);

    always_ff @(posedge i_up_clk) begin
        if (i_up_rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_tc      <= '0;
            r_sc      <= '0;
            r_retry   <= '0;
            r_loss    <= '0;
            r_timeout <= 1'b0;
            r_req_d   <= 1'b0;
            r_sync1   <= '0;
            r_sync2   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_tc      <= w_tc_nxt;
            r_sc      <= w_sc_nxt;
            r_retry   <= w_retry_nxt;
            r_loss    <= w_loss_nxt;
            r_timeout <= w_timeout_nxt;
            r_req_d   <= i_rst_req;
            r_sync1   <= i_gth_status;
            r_sync2   <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_tc_nxt      = r_tc;
        w_sc_nxt      = r_sc;
        w_retry_nxt   = r_retry;
        w_loss_nxt    = r_loss;
        w_timeout_nxt = r_timeout;

        if (w_req_edge) begin
            w_state_nxt   = S_ASSERT;
            w_pc_nxt      = '0;
            w_retry_nxt   = '0;
            w_timeout_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                end
                S_ASSERT: begin
                    if (r_pc == c_PC_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_tc_nxt    = '0;
                    end else begin
                        w_pc_nxt = r_pc + c_PC_W'(1);
                    end
                end
                S_WAIT_LOCK, S_SETTLE: begin
                    w_tc_nxt = r_tc + c_TC_W'(1);
                    // Settle completion beats a simultaneous timeout.
                    if ((r_state == S_SETTLE) && w_ok && (r_sc == c_SC_LAST)) begin
                        w_state_nxt = S_LOCKED;
                    end else if (w_tc_last) begin
                        w_timeout_nxt = 1'b1;
                        w_tc_nxt      = '0;
                        if (r_retry < c_MAX_RETRY) begin
                            w_retry_nxt = r_retry + 4'd1;
                            w_state_nxt = S_ASSERT;
                            w_pc_nxt    = '0;
                        end else begin
                            w_state_nxt = S_FAIL;
                        end
                    end else if (r_state == S_WAIT_LOCK) begin
                        if (w_ok) begin
                            w_state_nxt = S_SETTLE;
                            w_sc_nxt    = c_SC_W'(1);
                        end
                    end else if (!w_ok) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end else begin
                        w_sc_nxt = r_sc + c_SC_W'(1);
                    end
                end
                S_LOCKED: begin
                    if (!w_ok) begin
                        if (r_loss != 8'hFF) begin
                            w_loss_nxt = r_loss + 8'd1;
                        end
                        if (AUTO_RELOCK) begin
                            w_state_nxt = S_ASSERT;
                            w_pc_nxt    = '0;
                            w_retry_nxt = '0;
                        end else begin
                            w_state_nxt = S_WAIT_LOCK;
                            w_tc_nxt    = '0;
                        end
                    end
                end
                S_FAIL: begin
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign o_gth_rst   = (r_state == S_ASSERT);
    assign o_locked    = (r_state == S_LOCKED);
    assign o_busy      = (r_state == S_ASSERT) || (r_state == S_WAIT_LOCK) ||
                         (r_state == S_SETTLE);
    assign o_stat_word = {8'h00, r_retry, r_loss, r_sync2, 2'b00,
                          r_timeout, o_locked, o_busy, r_state};

endmodule
`default_nettype wire

// File: tb/tb_gth_rst_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_gth_rst_seq
// Brief    : Directed self-checking bench for gth_rst_seq (small parameters).
// Revision : 1.0 - initial release
// =============================================================================
module tb_gth_rst_seq;

    logic        clk;
    logic        rst;
    logic        rst_req;
    logic [3:0]  gth_status;
    logic        gth_rst;
    logic        locked;
    logic        busy;
    logic [31:0] stat_word;

    int total = 0;
    int bad   = 0;

    gth_rst_seq #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .SETTLE_CYCLES (3),
        .MAX_RETRY     (1),
        .LOCK_MASK     (4'hF),
        .AUTO_RELOCK   (1'b1)
    ) u_dut (
        .i_up_clk     (clk),
        .i_up_rst     (rst),
        .i_rst_req    (rst_req),
        .i_gth_status (gth_status),
        .o_gth_rst    (gth_rst),
        .o_locked     (locked),
        .o_busy       (busy),
        .o_stat_word  (stat_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int maxn, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((stat_word[2:0] != tgt) && (n < maxn));
    endtask

    initial begin
        int n;
        int highs;
        int rises;
        logic prev;

        // Reset with request held high and full status
        rst = 1'b1; rst_req = 1'b1; gth_status = 4'hF;
        step(); step(); step();
        chk("rst_gth_rst", gth_rst, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stat", stat_word, 32'h0);
        rst_req = 1'b0; rst = 1'b0;
        step();
        chk("sync_lat1", stat_word, 32'h0);
        step();
        chk("sync_lat2", stat_word, 32'h0000_0F00);

        // Nominal lock
        rst_req = 1'b1;
        step();
        chk("nom_assert", stat_word, 32'h0000_0F09);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("nom_pulse", gth_rst, 1);
        end
        step();
        chk("nom_pulse_end", gth_rst, 0);
        chk("nom_wait", stat_word, 32'h0000_0F0A);
        step(); chk("nom_settle1", stat_word, 32'h0000_0F0B);
        step(); chk("nom_settle2", stat_word[2:0], 3);
        step(); chk("nom_settle3", stat_word[2:0], 3);
        step();
        chk("nom_locked", stat_word, 32'h0000_0F14);
        chk("nom_locked_o", locked, 1);
        for (int i = 0; i < 5; i++) step();
        chk("hold_no_retrig", stat_word[2:0], 4);

        // Settle glitch
        rst_req = 1'b0; step();
        rst_req = 1'b1; step();
        chk("gl_assert", stat_word[2:0], 1);
        step(); step(); step(); step();
        chk("gl_wait", stat_word[2:0], 2);
        gth_status = 4'hE;
        step();
        gth_status = 4'hF;
        chk("gl_settle_a", stat_word[2:0], 3);
        step();
        chk("gl_sync_e", stat_word, 32'h0000_0E0B);
        step();
        chk("gl_back_wait", stat_word, 32'h0000_0F0A);
        step(); chk("gl_resettle1", stat_word[2:0], 3);
        step(); chk("gl_resettle2", stat_word[2:0], 3);
        step(); chk("gl_resettle3", stat_word[2:0], 3);
        step(); chk("gl_locked", stat_word[2:0], 4);

        // Timeout, one retry, then FAIL
        rst_req = 1'b0; gth_status = 4'h0;
        step();
        rst_req = 1'b1;
        step();
        chk("to_assert", gth_rst, 1);
        highs = 1; rises = 1; prev = 1'b1; n = 0;
        do begin
            step();
            n++;
            if (gth_rst) begin
                highs++;
                if (!prev) rises++;
            end
            prev = gth_rst;
        end while ((stat_word[2:0] != 3'd5) && (n < 100));
        chk("to_cycles", n, 48);
        chk("to_highs", highs, 8);
        chk("to_pulses", rises, 2);
        chk("to_fail_stat", stat_word, 32'h0010_0025);
        chk("to_fail_locked", locked, 0);
        step(); step(); step();
        chk("to_fail_hold", stat_word[2:0], 5);

        // New edge clears sticky and retry
        rst_req = 1'b0; step();
        rst_req = 1'b1; step();
        chk("re_clear", stat_word, 32'h0000_0009);
        wait_state(3'd2, 20, n); chk("re_pulse", n, 4);
        wait_state(3'd1, 40, n); chk("re_timeout", n, 20);
        chk("re_retry_stat", stat_word, 32'h0010_0029);
        wait_state(3'd2, 20, n); chk("re_pulse2", n, 4);
        step(); step();
        chk("mid_wait_retry1", stat_word, 32'h0010_002A);

        // Mid-sequence restart from WAIT_LOCK
        rst_req = 1'b0; step();
        rst_req = 1'b1; step();
        chk("mid_restart", stat_word, 32'h0000_0009);
        chk("mid_gth_rst", gth_rst, 1);
        gth_status = 4'hF;
        wait_state(3'd2, 20, n); chk("mid_pulse", n, 4);
        wait_state(3'd4, 40, n); chk("mid_lock_time", n, 4);
        chk("mid_locked", stat_word, 32'h0000_0F14);

        // Loss of lock, repeated to saturation
        for (int i = 1; i <= 256; i++) begin
            gth_status = 4'hB;
            wait_state(3'd1, 10, n);
            if (i == 1) begin
                chk("loss_latency", n, 3);
                chk("loss_cnt1", stat_word[19:12], 1);
                chk("loss_gth_rst", gth_rst, 1);
            end
            gth_status = 4'hF;
            wait_state(3'd2, 10, n);
            if (i == 1) chk("loss_pulse", n, 4);
            wait_state(3'd4, 20, n);
            chk("loss_relock", stat_word[2:0], 4);
            if (i == 255) chk("loss_cnt255", stat_word[19:12], 8'hFF);
        end
        chk("loss_sat", stat_word, 32'h000F_FF14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
